// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: WB / mult-div / debug sharing,
// busy-register scoreboard for in-flight mult-div results, and starvation stall.
module regfile_write_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_w,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [AWIDTH-1:0] mc_addr,
    input  logic [DWIDTH-1:0] mc_data,
    output logic              mc_ready,
    input  logic              dbg_req,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_data,
    output logic              dbg_ack,
    input  logic              iss_valid,
    input  logic [AWIDTH-1:0] iss_addr,
    input  logic [AWIDTH-1:0] chk_rs,
    input  logic [AWIDTH-1:0] chk_rt,
    input  logic [AWIDTH-1:0] chk_rd,
    output logic              hazard,
    output logic              force_stall,
    output logic              issue_err,
    output logic              w,
    output logic [AWIDTH-1:0] w_addr_reg,
    output logic [DWIDTH-1:0] w_data_reg
);

    localparam int NREG = 1 << AWIDTH;
    localparam int CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic {NORMAL, STARVE} state_t;

    state_t            state_q;
    logic              force_stall_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;
    logic              w_q, w_d;
    logic              src_mc_q, src_mc_d;
    logic [AWIDTH-1:0] w_addr_q, w_addr_d;
    logic [DWIDTH-1:0] w_data_q, w_data_d;

    logic wb_g, mc_g, dbg_g, any_g;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_data;
    logic clr, set, already;

    // WB loses its priority entirely while MC is being rescued from starvation
    always_comb begin
        wb_g  = wb_w && (state_q == NORMAL);
        mc_g  = mc_valid && !wb_g;
        dbg_g = dbg_req && !wb_g && !mc_valid;
        any_g = wb_g || mc_g || dbg_g;
    end

    assign mc_ready = mc_g;
    assign dbg_ack  = dbg_g;

    always_comb begin
        sel_addr = dbg_addr;
        sel_data = dbg_data;
        if (wb_g) begin
            sel_addr = wb_addr;
            sel_data = wb_data;
        end else if (mc_g) begin
            sel_addr = mc_addr;
            sel_data = mc_data;
        end
    end

    always_comb begin
        w_d      = any_g && (sel_addr != '0);
        src_mc_d = mc_g && (mc_addr != '0);
        w_addr_d = any_g ? sel_addr : w_addr_q;
        w_data_d = any_g ? sel_data : w_data_q;
    end

    // A register being released this cycle may be re-reserved at once
    always_comb begin
        clr     = w_q && src_mc_q;
        set     = iss_valid && (iss_addr != '0);
        already = busy_q[iss_addr] && !(clr && (w_addr_q == iss_addr));
        busy_d  = busy_q;
        if (clr) busy_d[w_addr_q] = 1'b0;
        if (set && !already) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
        err_d   = set && already;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!mc_valid || mc_g) cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    assign hazard = busy_q[chk_rs] | busy_q[chk_rt] | busy_q[chk_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            force_stall_q <= 1'b0;
        end else begin
            unique case (state_q)
                NORMAL: if (cnt_d == CNT_MAX) begin
                    state_q       <= STARVE;
                    force_stall_q <= 1'b1;
                end
                STARVE: if (mc_g) begin
                    state_q       <= NORMAL;
                    force_stall_q <= 1'b0;
                end
                default: begin
                    state_q       <= NORMAL;
                    force_stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            w_q      <= 1'b0;
            src_mc_q <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            w_q      <= w_d;
            src_mc_q <= src_mc_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign force_stall = force_stall_q;
    assign issue_err   = err_q;
    assign w           = w_q;
    assign w_addr_reg  = w_addr_q;
    assign w_data_reg  = w_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: expected regfile writes are queued as
// requests are driven and compared whenever the write port fires.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_w, mc_valid, dbg_req, iss_valid;
    logic [4:0]  wb_addr, mc_addr, dbg_addr, iss_addr;
    logic [31:0] wb_data, mc_data, dbg_data;
    logic [4:0]  chk_rs, chk_rt, chk_rd;
    logic        mc_ready, dbg_ack, hazard, force_stall, issue_err, w;
    logic [4:0]  w_addr_reg;
    logic [31:0] w_data_reg;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    regfile_write_arbiter #(.DWIDTH(32), .AWIDTH(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_w(wb_w), .wb_addr(wb_addr), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
        .mc_ready(mc_ready),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_ack(dbg_ack),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
        .hazard(hazard), .force_stall(force_stall), .issue_err(issue_err),
        .w(w), .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wb_w = 0; wb_addr = 0; wb_data = 0;
        mc_valid = 0; mc_addr = 0; mc_data = 0;
        dbg_req = 0; dbg_addr = 0; dbg_data = 0;
        iss_valid = 0; iss_addr = 0;
        chk_rs = 0; chk_rt = 0; chk_rd = 0;
    endtask

    // Write-port monitor: every write must match the next queued expectation
    always @(negedge clk) begin
        if (w === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("w_spurious", {63'd0, w}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("w_addr", {59'd0, w_addr_reg}, {59'd0, e.a});
                check("w_data", {32'd0, w_data_reg}, {32'd0, e.d});
            end
        end
    end

    initial begin
        rst = 1;
        idle();
        chk_rs = 8;
        tick(); tick();
        mid();
        check("rst_w", {63'd0, w}, 0);
        check("rst_stall", {63'd0, force_stall}, 0);
        check("rst_err", {63'd0, issue_err}, 0);
        check("rst_hazard", {63'd0, hazard}, 0);
        tick(); rst = 0; idle();

        // WB only
        tick(); wb_w = 1; wb_addr = 5; wb_data = 32'hA5; push(5, 32'hA5);
        mid(); check("t1_mc_ready", {63'd0, mc_ready}, 0);
        tick(); idle();
        mid(); check("t1_w", {63'd0, w}, 1);

        // Three-way collision
        tick();
        wb_w = 1; wb_addr = 3; wb_data = 32'h11;
        mc_valid = 1; mc_addr = 7; mc_data = 32'h22;
        dbg_req = 1; dbg_addr = 9; dbg_data = 32'h33;
        push(3, 32'h11);
        mid();
        check("t2_c1_mc_ready", {63'd0, mc_ready}, 0);
        check("t2_c1_dbg_ack", {63'd0, dbg_ack}, 0);
        tick(); wb_w = 0; push(7, 32'h22);
        mid();
        check("t2_c2_mc_ready", {63'd0, mc_ready}, 1);
        check("t2_c2_dbg_ack", {63'd0, dbg_ack}, 0);
        tick(); mc_valid = 0; push(9, 32'h33);
        mid(); check("t2_c3_dbg_ack", {63'd0, dbg_ack}, 1);
        tick(); idle();
        mid();

        // Scoreboard
        tick(); iss_valid = 1; iss_addr = 8; chk_rs = 8;
        mid(); check("t3_hz_pre", {63'd0, hazard}, 0);
        tick(); iss_valid = 0;
        mid();
        check("t3_hz_set", {63'd0, hazard}, 1);
        check("t3_err_none", {63'd0, issue_err}, 0);
        tick(); iss_valid = 1;
        mid();
        tick(); iss_valid = 0; chk_rs = 0; chk_rd = 8;
        mid();
        check("t3_err_busy", {63'd0, issue_err}, 1);
        check("t3_hz_rd", {63'd0, hazard}, 1);
        tick(); chk_rs = 8; chk_rd = 0;
        mc_valid = 1; mc_addr = 8; mc_data = 32'h88; push(8, 32'h88);
        mid();
        check("t3_err_pulse", {63'd0, issue_err}, 0);
        check("t3_mc_ready", {63'd0, mc_ready}, 1);
        tick(); mc_valid = 0; iss_valid = 1; iss_addr = 8;
        mid(); check("t3_hz_at_w", {63'd0, hazard}, 1);
        tick(); iss_valid = 0;
        mid();
        check("t3_reissue_hold", {63'd0, hazard}, 1);
        check("t3_reissue_err", {63'd0, issue_err}, 0);
        tick(); mc_valid = 1; mc_addr = 8; mc_data = 32'h99; push(8, 32'h99);
        mid();
        tick(); mc_valid = 0;
        mid(); check("t3_hz_during_w", {63'd0, hazard}, 1);
        tick();
        mid(); check("t3_hz_clear", {63'd0, hazard}, 0);

        // Starvation
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            wb_w = 1; wb_addr = 5'(16 + i); wb_data = 32'h100 + i;
            mc_valid = 1; mc_addr = 12; mc_data = 32'hCC;
            push(5'(16 + i), 32'h100 + i);
            mid();
            check("t4_mc_wait", {63'd0, mc_ready}, 0);
            check("t4_stall_lo", {63'd0, force_stall}, 0);
        end
        tick(); wb_addr = 20; wb_data = 32'hBAD; push(12, 32'hCC);
        mid();
        check("t4_stall_hi", {63'd0, force_stall}, 1);
        check("t4_mc_grant", {63'd0, mc_ready}, 1);
        tick(); idle();
        mid(); check("t4_stall_off", {63'd0, force_stall}, 0);

        // Reset in STARVE with a busy register and a live write
        tick(); iss_valid = 1; iss_addr = 8;
        for (int i = 0; i < 4; i++) begin
            tick(); iss_valid = 0;
            wb_w = 1; wb_addr = 5'(24 + i); wb_data = 32'h200 + i;
            mc_valid = 1; mc_addr = 13; mc_data = 32'hDD;
            push(5'(24 + i), 32'h200 + i);
            mid();
        end
        tick(); rst = 1;
        mid();
        check("t5_pre_stall", {63'd0, force_stall}, 1);
        check("t5_pre_w", {63'd0, w}, 1);
        tick(); rst = 0; idle(); chk_rs = 8;
        mid();
        check("t5_w", {63'd0, w}, 0);
        check("t5_stall", {63'd0, force_stall}, 0);
        check("t5_err", {63'd0, issue_err}, 0);
        check("t5_hazard", {63'd0, hazard}, 0);
        check("t5_waddr", {59'd0, w_addr_reg}, 0);
        check("t5_wdata", {32'd0, w_data_reg}, 0);
        tick();
        wb_w = 1; wb_addr = 4; wb_data = 32'h44;
        mc_valid = 1; mc_addr = 13; mc_data = 32'hDD;
        push(4, 32'h44);
        mid(); check("t5_normal", {63'd0, mc_ready}, 0);
        tick(); wb_w = 0; push(13, 32'hDD);
        mid(); check("t5_mc_ready", {63'd0, mc_ready}, 1);
        tick(); idle();
        mid();

        // Register zero
        tick();
        wb_w = 1; wb_data = 32'h1;
        mc_valid = 1; mc_data = 32'h2;
        dbg_req = 1; dbg_data = 32'h3;
        mid();
        check("t6_c1_mc_ready", {63'd0, mc_ready}, 0);
        check("t6_c1_dbg_ack", {63'd0, dbg_ack}, 0);
        tick(); wb_w = 0;
        mid(); check("t6_c2_mc_ready", {63'd0, mc_ready}, 1);
        tick(); mc_valid = 0; iss_valid = 1; iss_addr = 0;
        mid();
        check("t6_c3_dbg_ack", {63'd0, dbg_ack}, 1);
        check("t6_hz0", {63'd0, hazard}, 0);
        tick(); idle();
        mid();
        check("t6_w0", {63'd0, w}, 0);
        check("t6_hz0_after", {63'd0, hazard}, 0);
        tick(); iss_valid = 1;
        mid();
        tick(); idle();
        mid(); check("t6_err0", {63'd0, issue_err}, 0);

        tick(); tick();
        mid();
        check("q_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
